// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and the
// default requester count / counter width used by counter_scheduler.
package counter_sched_pkg;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sched_counter.sv
// WIDTH-bit shared up-counter used by counter_scheduler.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset, clears count
//   clr    - synchronous clear to 0, has priority over en
//   en     - increment by 1 when set
//   count  - registered counter value
module sched_counter #(
    parameter int WIDTH = counter_sched_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit counter among N_REQ requesters.
// The winner's target is latched at grant, the counter is cleared and run up
// to that target, and a one-cycle done pulse is returned to the owner.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   req    - per-requester request level
//   target - packed targets, requester i at [i*WIDTH +: WIDTH]
//   gnt    - registered one-hot grant
//   done   - registered one-cycle completion pulse (granted bit only)
//   busy   - high whenever the FSM is not IDLE
//   count  - shared counter value
module counter_scheduler #(
    parameter int N_REQ = counter_sched_pkg::N_REQ,
    parameter int WIDTH = counter_sched_pkg::WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] target,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [WIDTH-1:0]       count
);

    import counter_sched_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;     // last served (or aborted) requester
    logic [IDX_W-1:0] own_q, own_d;     // index of the current grant owner
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic             cnt_clr;
    logic             cnt_en;

    sched_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    // Round-robin search: first set req starting just above the pointer, so
    // the requester served last has the lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_vld && req[(int'(ptr_q) + k) % N_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        tgt_d   = tgt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = RUN;
                    own_d   = win_idx;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    tgt_d   = target[win_idx*WIDTH +: WIDTH];
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                if (!req[own_q]) begin
                    // Owner withdrew: release without a done pulse.
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = own_q;
                end else if (count == tgt_q) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                // A req drop here is ignored; the pulse already went out.
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = own_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            own_q   <= '0;
            tgt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            tgt_q   <= tgt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_counter_scheduler.sv
module tb_counter_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] target;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;

    int vectors;
    int errors;

    counter_scheduler #(.N_REQ(4), .WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .target (target),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        req    = 4'b1111;
        target = '0;
        #3;
        vectors++;
        if ({gnt, done, busy, count} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b done=%b busy=%b count=%0d, want all 0",
                     gnt, done, busy, count);
        end
        #9 reset = 1'b1;   // release between edges
        step();
        vectors++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b busy=%b count=%0d, want 0001 1 0",
                     gnt, busy, count);
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin
            errors++;
            $display("FAIL reset_abort: gnt=%b done=%b, want 0000 0000", gnt, done);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_cnt [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
        req           = 4'b0100;
        target[8 +: 4] = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (gnt !== 4'b0100 || count !== exp_cnt[i] || busy !== 1'b1 ||
                done !== ((i == 4) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL single_c%0d: gnt=%b count=%0d busy=%b done=%b, want 0100 %0d 1 %b",
                         i, gnt, count, busy, done, exp_cnt[i], (i == 4) ? 4'b0100 : 4'b0000);
            end
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%b done=%b busy=%b, want 0000 0000 0",
                     gnt, done, busy);
        end
    endtask

    // Requester 2 was served last, so the rotation starts at requester 3.
    task automatic test_round_robin();
        logic [3:0] order [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] eg, ed;
        target = 16'h1111;
        req    = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step();
            eg = (c % 4 == 3) ? 4'b0000 : order[c / 4];
            ed = (c % 4 == 2) ? order[c / 4] : 4'b0000;
            vectors++;
            if (gnt !== eg || done !== ed) begin
                errors++;
                $display("FAIL rr_c%0d: gnt=%b done=%b, want %b %b", c, gnt, done, eg, ed);
            end
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: gnt=%b busy=%b, want 0000 0", gnt, busy);
        end
    endtask

    task automatic test_bounds();
        // Target 0: two grant cycles, done with count 0.
        req            = 4'b0001;
        target         = '0;
        step();
        vectors++;
        if (gnt !== 4'b0001 || count !== 4'd0 || done !== 4'b0000) begin
            errors++;
            $display("FAIL t0_grant: gnt=%b count=%0d done=%b, want 0001 0 0000", gnt, count, done);
        end
        step();
        vectors++;
        if (gnt !== 4'b0001 || count !== 4'd0 || done !== 4'b0001) begin
            errors++;
            $display("FAIL t0_done: gnt=%b count=%0d done=%b, want 0001 0 0001", gnt, count, done);
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin
            errors++;
            $display("FAIL t0_release: gnt=%b done=%b, want 0000 0000", gnt, done);
        end
        // Target 15: count stops at 15; a mid-run target change is ignored.
        req             = 4'b1000;
        target[12 +: 4] = 4'd15;
        for (int i = 0; i < 17; i++) begin
            step();
            if (i == 3) target[12 +: 4] = 4'd2;
            vectors++;
            if (gnt !== 4'b1000 || count !== ((i < 16) ? 4'(i) : 4'd15) ||
                done !== ((i == 16) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL t15_c%0d: gnt=%b count=%0d done=%b, want 1000 %0d %b",
                         i, gnt, count, done, (i < 16) ? i : 15, (i == 16) ? 4'b1000 : 4'b0000);
            end
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || count !== 4'd15) begin
            errors++;
            $display("FAIL t15_release: gnt=%b count=%0d, want 0000 15", gnt, count);
        end
    endtask

    // Pointer sits at 3, so requester 1 wins over 3; dropping it hands over to 3.
    task automatic test_abort();
        req            = 4'b1010;
        target[4 +: 4]  = 4'd9;
        target[12 +: 4] = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (gnt !== 4'b0010 || count !== 4'(i) || done !== 4'b0000) begin
                errors++;
                $display("FAIL abort_run_c%0d: gnt=%b count=%0d done=%b, want 0010 %0d 0000",
                         i, gnt, count, done, i);
            end
        end
        req = 4'b1000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: gnt=%b done=%b busy=%b, want 0000 0000 0", gnt, done, busy);
        end
        step();
        vectors++;
        if (gnt !== 4'b1000 || count !== 4'd0) begin
            errors++;
            $display("FAIL abort_next: gnt=%b count=%0d, want 1000 0", gnt, count);
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin
            errors++;
            $display("FAIL abort_next_drop: gnt=%b done=%b, want 0000 0000", gnt, done);
        end
    endtask

    task automatic test_reset_mid();
        req            = 4'b0001;
        target[0 +: 4] = 4'd9;
        step();
        step();
        step();
        vectors++;
        if (gnt !== 4'b0001 || count !== 4'd2) begin
            errors++;
            $display("FAIL rmid_pre: gnt=%b count=%0d, want 0001 2", gnt, count);
        end
        req = 4'b1111;
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({gnt, done, busy, count} !== 13'd0) begin
            errors++;
            $display("FAIL rmid_async: gnt=%b done=%b busy=%b count=%0d, want all 0",
                     gnt, done, busy, count);
        end
        #4 reset = 1'b1;
        step();
        vectors++;
        if (gnt !== 4'b0001 || done !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_regrant: gnt=%b done=%b, want 0001 0000", gnt, done);
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release: gnt=%b busy=%b, want 0000 0", gnt, busy);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_bounds();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares one 4-bit enabled up-counter among four requesters. Each requester asks for a timed interval by presenting a target count. The scheduler grants one requester at a time, clears and runs the shared counter until it reaches that target, then pulses `done` back to the owner. It sits between the flip-flop/counter datapath blocks and any logic needing short cycle-accurate delays.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters. Fixed at 4 for this release.
- `WIDTH`, 4: counter and target width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level. Held until `done` or withdrawn.
- `target`  in  N_REQ*WIDTH  packed targets; requester i occupies bits [i*WIDTH +: WIDTH].
- `gnt`  out  N_REQ  one-hot grant, registered.
- `done`  out  N_REQ  one-cycle completion pulse, registered; only the granted bit may be set.
- `busy`  out  1  high whenever state ≠ IDLE.
- `count`  out  WIDTH  shared counter value, registered.

## Operation
- States: IDLE, RUN, DONE.
- **Reset values:** all outputs 0, state IDLE, RR pointer = N_REQ-1 so requester 0 wins first.
- **IDLE**
  - If no `req` is set: hold; `count` keeps its last value.
  - If any `req` is set: pick the first set bit searching upward from pointer+1 (mod N_REQ).
  - At that edge: set `gnt` for the winner, latch its target into `tgt_q`, clear `count` to 0, go to RUN.
- **RUN**, evaluated each edge in priority order:
  1. Granted `req` deasserted → abort: `gnt` to 0, pointer = granted index, go to IDLE, no `done`.
  2. `count == tgt_q` → go to DONE, `count` holds.
  3. Otherwise `count` increments by 1.
- **DONE**
  - `done[g]` is high for exactly this cycle; `gnt[g]` is still high.
  - Next edge: `gnt` and `done` go to 0, pointer = g, go to IDLE.
  - A `req` drop while in DONE is ignored; `done` still pulses.
- **Arithmetic:** `count` never exceeds `tgt_q`, so it never wraps. Target 15 is legal, and `count` stops at 15.
- **Target sampling:** `target` is sampled only at grant; changes during RUN are ignored. Target 0 is legal: RUN lasts one cycle, then DONE.
- **Simultaneous requests:** resolved purely round-robin. A requester that was just served has the lowest priority on the next grant.
- **Back-to-back requests:** a requester re-asserting `req` after `done` is treated as a new request.
- **Reset mid-operation:** every register returns to its reset value immediately; no `done` is produced.

## Timing
- Define E0 as the IDLE edge that samples `req`. For target T with no abort:
  - `gnt` rises after E0, with `count` = 0.
  - `count` = T after edge E_T.
  - State DONE and `done` high after E_{T+1}.
  - `gnt` and `done` low after E_{T+2}, so `gnt` is high for T+2 cycles.
- The next grant is issued at E_{T+3} at the earliest, which is one idle cycle between grants.
- `req`-to-`gnt` latency is 1 edge.
- All outputs come from flops; there are no combinational input-to-output paths.

## Structure
- **Shared package `counter_sched_pkg`:** state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), `N_REQ`, `WIDTH`.
- **Sub-module `sched_counter`:** WIDTH-bit counter with ports `clk`, `reset` (async active-low), `clr`, `en`, `count`.
  - `clr` has priority over `en`.
  - The scheduler drives `clr` at grant and `en` in RUN while `count != tgt_q`.
- **Top module:** holds the FSM, round-robin pointer, `tgt_q`, and the grant/done registers.

## Test plan
- Reset with `reset`=0 and all `req` set → all outputs 0. After release, `gnt`=0001 one edge later.
- `req`=0100, target[2]=3 → `gnt`=0100 for 5 cycles; `count` runs 0,1,2,3,3; `done`=0100 for one cycle in the last `gnt` cycle; `busy` falls with `gnt`.
- `req`=1111, all targets=1, held continuously → grant order 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle between grants.
- Targets 0 and 15 → target 0 gives `gnt` for 2 cycles and `done` with `count`=0. Target 15 gives `count` stopping at 15 with no wrap, and `gnt` for 17 cycles.
- `req[1]` dropped when `count`=2 (target 9) → `gnt` low next edge, no `done`; pending `req[3]` is granted on the following edge.
- `reset` asserted during RUN → `gnt`, `done`, `count`, `busy` are 0 immediately, before the next clock edge. After release, the next grant goes to requester 0 if requesting.
